// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 two-client arbiter.
package l2_arb_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned LINE_W   = 256;
  // Byte offset within a 32-byte line; these address bits never reach the L2.
  localparam int unsigned OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    CLI_I,
    CLI_D
  } client_t;

endpackage

// File: rtl/l2_arb_req_latch.sv
// Load-enabled holding register for the granted request, so the L2 sees
// stable op/address/data for the whole transaction.
module l2_arb_req_latch #(
  parameter int unsigned ADDR_W   = l2_arb_pkg::ADDR_W,
  parameter int unsigned LINE_W   = l2_arb_pkg::LINE_W,
  parameter int unsigned OFFSET_W = l2_arb_pkg::OFFSET_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       op_read_d,
  input  logic                       op_write_d,
  input  logic [ADDR_W-1:OFFSET_W]   addr_d,
  input  logic [LINE_W-1:0]          wdata_d,
  output logic                       op_read_q,
  output logic                       op_write_q,
  output logic [ADDR_W-1:OFFSET_W]   addr_q,
  output logic [LINE_W-1:0]          wdata_q
);

  // Capture the granted request on load; cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_read_q  <= 1'b0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (load) begin
      op_read_q  <= op_read_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Two-client (I-cache / D-cache) arbiter in front of the L2 port.
// Round-robin by default, fixed D-cache priority when D_PRIORITY != 0.
module l2_arbiter #(
  parameter int unsigned ADDR_W     = l2_arb_pkg::ADDR_W,
  parameter int unsigned LINE_W     = l2_arb_pkg::LINE_W,
  parameter int unsigned D_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  import l2_arb_pkg::*;

  arb_state_t state_q;
  client_t    rr_last_q;

  logic req_i, req_d, grant_i, grant_d, load;
  logic sel_read, sel_write;
  logic [ADDR_W-1:OFFSET_W] sel_addr;
  logic [LINE_W-1:0]        sel_wdata;

  logic                     op_read_q, op_write_q;
  logic [ADDR_W-1:OFFSET_W] addr_q;
  logic [LINE_W-1:0]        wdata_q;
  logic                     busy;

  // Line offset bits are intentionally dropped.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{i_address[OFFSET_W-1:0], d_address[OFFSET_W-1:0]};

  // Grant decision and selection of the winning client's request.
  always_comb begin
    req_i   = i_read | i_write;
    req_d   = d_read | d_write;
    // D wins if alone, under fixed priority, or when I was served last.
    grant_d = req_d && (!req_i || (D_PRIORITY != 0) || (rr_last_q == CLI_I));
    grant_i = req_i && !grant_d;
    load    = (state_q == IDLE) && (grant_i || grant_d);
    // Write takes precedence over a simultaneous read from the same client.
    if (grant_d) begin
      sel_read  = d_read & ~d_write;
      sel_write = d_write;
      sel_addr  = d_address[ADDR_W-1:OFFSET_W];
      sel_wdata = d_wdata;
    end else begin
      sel_read  = i_read & ~i_write;
      sel_write = i_write;
      sel_addr  = i_address[ADDR_W-1:OFFSET_W];
      sel_wdata = i_wdata;
    end
  end

  l2_arb_req_latch #(
    .ADDR_W   (ADDR_W),
    .LINE_W   (LINE_W),
    .OFFSET_W (OFFSET_W)
  ) u_req_latch (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .op_read_d  (sel_read),
    .op_write_d (sel_write),
    .addr_d     (sel_addr),
    .wdata_d    (sel_wdata),
    .op_read_q  (op_read_q),
    .op_write_q (op_write_q),
    .addr_q     (addr_q),
    .wdata_q    (wdata_q)
  );

  // Arbitration FSM: grant from IDLE, return to IDLE on the L2 completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= CLI_I;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q <= BUSY_D;
          end else if (grant_i) begin
            state_q <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (l2_resp) begin
            state_q   <= IDLE;
            rr_last_q <= CLI_I;
          end
        end
        BUSY_D: begin
          if (l2_resp) begin
            state_q   <= IDLE;
            rr_last_q <= CLI_D;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // L2 request driven only from registered state; responses steered to the owner.
  always_comb begin
    busy       = (state_q != IDLE);
    l2_read    = busy & op_read_q;
    l2_write   = busy & op_write_q;
    l2_address = {addr_q, {OFFSET_W{1'b0}}};
    l2_wdata   = wdata_q;
    i_resp     = (state_q == BUSY_I) & l2_resp;
    d_resp     = (state_q == BUSY_D) & l2_resp;
    i_rdata    = l2_rdata;
    d_rdata    = l2_rdata;
  end

endmodule
